pipeline_cmd_issuer: RTL

PIPELINE_CMD_ISSUER -- requirements
Module: pipeline_cmd_issuer

---
 rtl/pipeline_cmd_issuer_pkg.sv | 46 ++++
 rtl/pipeline_cmd_issuer_byte_shifter.sv | 52 +++++
 rtl/pipeline_cmd_issuer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_cmd_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_cmd_issuer_pkg
// Description : Shared definitions for the pipeline command issuer: opcode
//               values, FSM state encoding and payload-length helpers.
//               Ports : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_cmd_issuer_pkg;

    localparam logic [7:0] c_OP_WRITE_INSTR = 8'h01;
    localparam logic [7:0] c_OP_WRITE_REG   = 8'h02;
    localparam logic [7:0] c_OP_UPDATE      = 8'h03;
    localparam logic [7:0] c_OP_ALLOC       = 8'h04;

    // Width of the payload byte counter; comfortably covers every payload.
    localparam int c_LEN_W = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PAYLOAD  = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == c_OP_WRITE_INSTR) || (op == c_OP_WRITE_REG) ||
               (op == c_OP_UPDATE)      || (op == c_OP_ALLOC);
    endfunction

    // Number of payload bytes following an opcode byte.
    function automatic logic [c_LEN_W-1:0] payload_len(input logic [7:0] op,
                                                       input int iw,
                                                       input int dw);
        logic [c_LEN_W-1:0] len;
        case (op)
            c_OP_WRITE_INSTR: len = c_LEN_W'(1 + iw / 8);
            c_OP_WRITE_REG:   len = c_LEN_W'(2 + dw / 8);
            c_OP_ALLOC:       len = c_LEN_W'(3 * dw / 8);
            default:          len = '0;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_cmd_issuer_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_byte_shifter
// Description : Payload byte counter plus MSB-first shift register. The
//               combinational o_next shows the register contents including
//               the byte being accepted now, so the caller can latch complete
//               fields on the same edge that takes the final byte.
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : start a new payload of i_len bytes (clears history)
//   i_shift   : shift i_byte in (ignored when no bytes remain)
//   o_last    : exactly one payload byte remains
//   o_next    : {history, i_byte}, right-aligned payload
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_byte_shifter #(
    parameter int SHIFT_W = 48,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [CNT_W-1:0]   i_len,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic               o_last,
    output logic [SHIFT_W-1:0] o_next
);

    logic [CNT_W-1:0]   r_cnt;
    // Only the older bytes are stored; the newest byte comes straight from i_byte.
    logic [SHIFT_W-9:0] r_hist;
    logic [SHIFT_W-1:0] w_next;

    assign w_next = {r_hist, i_byte};
    assign o_next = w_next;
    assign o_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hist <= '0;
        end else if (i_load) begin
            r_cnt  <= i_len;
            r_hist <= '0;
        end else if (i_shift && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_hist <= w_next[SHIFT_W-9:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_cmd_issuer
// Description : Parses a byte-serial command stream (opcode + big-endian
//               payload) and issues single-cycle write/update/alloc strobes,
//               waiting for acks on the write commands with a timeout.
//   clk, reset              : clock, synchronous active-high reset
//   in_byte/_valid/_ready   : command byte stream handshake
//   block_target, reg_target, instr_val, ctrl_data, buf_init_delay
//                           : latched command fields (held until overwritten)
//   instr_write, reg_write, reg_update, alloc_delay : 1-cycle strobes
//   instr_write_ack, reg_write_ack : acks for the write strobes
//   resetting               : downstream busy-resetting, holds issue
//   busy, error, cmd_count  : status (error sticky until reset)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_cmd_issuer
    import pipeline_cmd_issuer_pkg::*;
#(
    parameter int n_blocks    = 256,
    parameter int data_width  = 16,
    parameter int instr_width = 32,
    parameter int ack_timeout = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_byte,
    input  logic                          in_byte_valid,
    output logic                          in_byte_ready,
    output logic [$clog2(n_blocks)-1:0]   block_target,
    output logic [$clog2(n_blocks)+3:0]   reg_target,
    output logic [instr_width-1:0]        instr_val,
    output logic [data_width-1:0]         ctrl_data,
    output logic [2*data_width-1:0]       buf_init_delay,
    output logic                          instr_write,
    output logic                          reg_write,
    output logic                          reg_update,
    output logic                          alloc_delay,
    input  logic                          instr_write_ack,
    input  logic                          reg_write_ack,
    input  logic                          resetting,
    output logic                          busy,
    output logic                          error,
    output logic [15:0]                   cmd_count
);

    localparam int c_BLK_W   = $clog2(n_blocks);
    localparam int c_W_INSTR = 8 + instr_width;
    localparam int c_W_REG   = 16 + data_width;
    localparam int c_W_ALLOC = 3 * data_width;
    localparam int c_W_IR    = (c_W_INSTR > c_W_REG) ? c_W_INSTR : c_W_REG;
    localparam int c_SHIFT_W = (c_W_IR > c_W_ALLOC) ? c_W_IR : c_W_ALLOC;
    localparam int c_TO_W    = $clog2(ack_timeout + 1);

    state_t                   r_state;
    logic [7:0]               r_op;
    logic                     r_fired;
    logic [c_TO_W-1:0]        r_to_cnt;
    logic [c_BLK_W-1:0]       r_block;
    logic [c_BLK_W+3:0]       r_reg_target;
    logic [instr_width-1:0]   r_instr;
    logic [data_width-1:0]    r_ctrl;
    logic [2*data_width-1:0]  r_delay;
    logic                     r_instr_write;
    logic                     r_reg_write;
    logic                     r_reg_update;
    logic                     r_alloc_delay;
    logic                     r_error;
    logic [15:0]              r_cmd_count;

    logic                     w_ready;
    logic                     w_op_known;
    logic [c_LEN_W-1:0]       w_len;
    logic                     w_sh_load;
    logic                     w_sh_shift;
    logic                     w_sh_last;
    logic [c_SHIFT_W-1:0]     w_sh_next;
    logic                     w_needs_ack;
    logic                     w_ack_match;

    assign w_ready     = (r_state == S_IDLE) || (r_state == S_PAYLOAD);
    assign w_op_known  = op_known(in_byte);
    assign w_len       = payload_len(in_byte, instr_width, data_width);
    assign w_sh_load   = (r_state == S_IDLE) && in_byte_valid && w_op_known;
    assign w_sh_shift  = (r_state == S_PAYLOAD) && in_byte_valid;
    assign w_needs_ack = (r_op == c_OP_WRITE_INSTR) || (r_op == c_OP_WRITE_REG);
    // Only the ack belonging to the command in flight is looked at.
    assign w_ack_match = ((r_op == c_OP_WRITE_INSTR) && instr_write_ack) ||
                         ((r_op == c_OP_WRITE_REG)   && reg_write_ack);

    cmd_byte_shifter #(
        .SHIFT_W (c_SHIFT_W),
        .CNT_W   (c_LEN_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_sh_load),
        .i_len   (w_len),
        .i_shift (w_sh_shift),
        .i_byte  (in_byte),
        .o_last  (w_sh_last),
        .o_next  (w_sh_next)
    );

    // ISSUE has two phases tracked by r_fired: first wait for resetting to be
    // low and arm the strobe register, then the strobe is visible for one
    // cycle (the "strobe cycle"), during which an ack already counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_fired       <= 1'b0;
            r_to_cnt      <= '0;
            r_block       <= '0;
            r_reg_target  <= '0;
            r_instr       <= '0;
            r_ctrl        <= '0;
            r_delay       <= '0;
            r_instr_write <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_update  <= 1'b0;
            r_alloc_delay <= 1'b0;
            r_error       <= 1'b0;
            r_cmd_count   <= '0;
        end else begin
            r_instr_write <= 1'b0;
            r_reg_write   <= 1'b0;
            r_reg_update  <= 1'b0;
            r_alloc_delay <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_byte_valid) begin
                        if (w_op_known) begin
                            r_op    <= in_byte;
                            r_state <= (w_len == '0) ? S_ISSUE : S_PAYLOAD;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (in_byte_valid && w_sh_last) begin
                        case (r_op)
                            c_OP_WRITE_INSTR: begin
                                r_block <= w_sh_next[instr_width +: c_BLK_W];
                                r_instr <= w_sh_next[instr_width-1:0];
                            end
                            c_OP_WRITE_REG: begin
                                r_reg_target <= {w_sh_next[data_width+8 +: c_BLK_W],
                                                 w_sh_next[data_width +: 4]};
                                r_ctrl       <= w_sh_next[data_width-1:0];
                            end
                            c_OP_ALLOC: begin
                                r_ctrl  <= w_sh_next[2*data_width +: data_width];
                                r_delay <= w_sh_next[2*data_width-1:0];
                            end
                            default: ;
                        endcase
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_fired) begin
                        r_fired <= 1'b0;
                        if (w_needs_ack && !w_ack_match) begin
                            r_to_cnt <= '0;
                            r_state  <= S_WAIT_ACK;
                        end else begin
                            r_cmd_count <= r_cmd_count + 16'd1;
                            r_state     <= S_IDLE;
                        end
                    end else if (!resetting) begin
                        r_fired <= 1'b1;
                        case (r_op)
                            c_OP_WRITE_INSTR: r_instr_write <= 1'b1;
                            c_OP_WRITE_REG:   r_reg_write   <= 1'b1;
                            c_OP_UPDATE:      r_reg_update  <= 1'b1;
                            default:          r_alloc_delay <= 1'b1;
                        endcase
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_match) begin
                        r_cmd_count <= r_cmd_count + 16'd1;
                        r_state     <= S_IDLE;
                    end else if (r_to_cnt == c_TO_W'(ack_timeout - 1)) begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_byte_ready  = w_ready;
    assign busy           = (r_state != S_IDLE);
    assign block_target   = r_block;
    assign reg_target     = r_reg_target;
    assign instr_val      = r_instr;
    assign ctrl_data      = r_ctrl;
    assign buf_init_delay = r_delay;
    assign instr_write    = r_instr_write;
    assign reg_write      = r_reg_write;
    assign reg_update     = r_reg_update;
    assign alloc_delay    = r_alloc_delay;
    assign error          = r_error;
    assign cmd_count      = r_cmd_count;

endmodule
`default_nettype wire
